// File: rtl/bus_pkg.sv
// Shared types and constants for the 23-bit word-address / 16-bit data peripheral bus.
package bus_pkg;

   localparam int unsigned ADDR_W = 23;
   localparam int unsigned DATA_W = 16;

   typedef logic [ADDR_W-1:0] bus_addr_t;
   typedef logic [DATA_W-1:0] bus_data_t;

   typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} initiator_state_t;

   localparam bus_addr_t DEFAULT_LED_ADDR = 23'h123456;
   localparam bus_addr_t DEFAULT_SW_ADDR  = 23'h123457;

endpackage

// File: rtl/bus_initiator.sv
// Bus master: each accepted valid/ready command becomes one bus strobe and one response pulse.
// Define BUS_INITIATOR_MIRROR_EN to add the periodic switch-to-LED mirror sequencer.
module bus_initiator
   import bus_pkg::*;
#(
   parameter int unsigned READ_LATENCY  = 1
`ifdef BUS_INITIATOR_MIRROR_EN
   ,
   parameter bus_addr_t   LED_ADDR      = DEFAULT_LED_ADDR,
   parameter bus_addr_t   SW_ADDR       = DEFAULT_SW_ADDR,
   parameter int unsigned MIRROR_PERIOD = 1000
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] bus_address,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              read_enable,
   output logic              write_enable,
   output logic              busy
);

   initiator_state_t state_q, state_d;
   bus_addr_t        addr_q, addr_d;
   bus_data_t        wdata_q, wdata_d;
   logic [3:0]       wait_q, wait_d;

   bus_addr_t        bus_address_q, bus_address_d;
   bus_data_t        bus_wdata_q, bus_wdata_d;
   bus_data_t        rsp_rdata_q, rsp_rdata_d;
   logic             read_enable_q, read_enable_d;
   logic             write_enable_q, write_enable_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;

`ifdef BUS_INITIATOR_MIRROR_EN
   // mirror_q marks an internal SW->LED sequence; phase_q is set once its write half has started.
   logic        mirror_q, mirror_d;
   logic        phase_q, phase_d;
   logic [15:0] per_q, per_d;
   logic        wrap;

   assign wrap  = (per_q == 16'(MIRROR_PERIOD - 1));
   assign per_d = wrap ? 16'd0 : per_q + 16'd1;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wait_d      = wait_q;
      rsp_rdata_d = rsp_rdata_q;
`ifdef BUS_INITIATOR_MIRROR_EN
      mirror_d    = mirror_q;
      phase_d     = phase_q;
`endif

      unique case (state_q)
         IDLE: begin
            // A pending command wins over a coincident mirror wrap.
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               state_d = cmd_write ? WRITE : READ;
            end
`ifdef BUS_INITIATOR_MIRROR_EN
            else if (wrap) begin
               addr_d   = SW_ADDR;
               mirror_d = 1'b1;
               phase_d  = 1'b0;
               state_d  = READ;
            end
`endif
         end
         WRITE: begin
            state_d = RESP;
`ifdef BUS_INITIATOR_MIRROR_EN
            if (!mirror_q)
`endif
               rsp_rdata_d = '0;
         end
         READ: begin
            wait_d  = 4'(READ_LATENCY);
            state_d = WAIT;
         end
         WAIT: begin
            if (wait_q == 4'd1) begin
               state_d = RESP;
`ifdef BUS_INITIATOR_MIRROR_EN
               if (mirror_q) begin
                  wdata_d = bus_rdata;
                  addr_d  = LED_ADDR;
               end else
`endif
                  rsp_rdata_d = bus_rdata;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         RESP: begin
`ifdef BUS_INITIATOR_MIRROR_EN
            if (mirror_q && !phase_q) begin
               state_d = WRITE;
               phase_d = 1'b1;
            end else begin
               state_d  = IDLE;
               mirror_d = 1'b0;
               phase_d  = 1'b0;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so strobes line up with their state cycle.
      read_enable_d  = (state_d == READ);
      write_enable_d = (state_d == WRITE);
      busy_d         = (state_d != IDLE);
      rsp_valid_d    = (state_d == RESP);
`ifdef BUS_INITIATOR_MIRROR_EN
      if (mirror_d) rsp_valid_d = 1'b0;
`endif
      bus_address_d  = (read_enable_d || write_enable_d) ? addr_d : bus_address_q;
      bus_wdata_d    = write_enable_d ? wdata_d : bus_wdata_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         wdata_q        <= '0;
         wait_q         <= '0;
         bus_address_q  <= '0;
         bus_wdata_q    <= '0;
         rsp_rdata_q    <= '0;
         read_enable_q  <= 1'b0;
         write_enable_q <= 1'b0;
         rsp_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         wait_q         <= wait_d;
         bus_address_q  <= bus_address_d;
         bus_wdata_q    <= bus_wdata_d;
         rsp_rdata_q    <= rsp_rdata_d;
         read_enable_q  <= read_enable_d;
         write_enable_q <= write_enable_d;
         rsp_valid_q    <= rsp_valid_d;
         busy_q         <= busy_d;
      end
   end

`ifdef BUS_INITIATOR_MIRROR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mirror_q <= 1'b0;
         phase_q  <= 1'b0;
         per_q    <= '0;
      end else begin
         mirror_q <= mirror_d;
         phase_q  <= phase_d;
         per_q    <= per_d;
      end
   end
`endif

   assign cmd_ready    = (state_q == IDLE);
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign bus_address  = bus_address_q;
   assign bus_wdata    = bus_wdata_q;
   assign read_enable  = read_enable_q;
   assign write_enable = write_enable_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: instance A (latency 1) with an LED/switch model,
// instance B (latency 4) with a time-varying read source, and a mirror instance when enabled.
`timescale 1ns/1ps
module tb_bus_initiator;
   import bus_pkg::*;

   localparam bus_addr_t LED = 23'h123456;
   localparam bus_addr_t SW  = 23'h123457;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [15:0] cyc = '0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 16'd1;

   logic a_cmd_valid = 0, a_cmd_write = 0, a_cmd_ready, a_rsp_valid;
   logic a_read_enable, a_write_enable, a_busy;
   logic [22:0] a_cmd_addr = '0, a_bus_address;
   logic [15:0] a_cmd_wdata = '0, a_rsp_rdata, a_bus_wdata, a_bus_rdata, a_led;

   logic b_cmd_valid = 0, b_cmd_write = 0, b_cmd_ready, b_rsp_valid;
   logic b_read_enable, b_write_enable, b_busy;
   logic [22:0] b_cmd_addr = '0, b_bus_address;
   logic [15:0] b_cmd_wdata = '0, b_rsp_rdata, b_bus_wdata, b_bus_rdata;

   bus_initiator #(
      .READ_LATENCY(1)
`ifdef BUS_INITIATOR_MIRROR_EN
      , .MIRROR_PERIOD(65535)
`endif
   ) u_a (
      .clk(clk), .reset(reset), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_write(a_cmd_write), .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .bus_address(a_bus_address),
      .bus_wdata(a_bus_wdata), .bus_rdata(a_bus_rdata), .read_enable(a_read_enable),
      .write_enable(a_write_enable), .busy(a_busy)
   );

   bus_initiator #(
      .READ_LATENCY(4)
`ifdef BUS_INITIATOR_MIRROR_EN
      , .MIRROR_PERIOD(65535)
`endif
   ) u_b (
      .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_write(b_cmd_write), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .bus_address(b_bus_address),
      .bus_wdata(b_bus_wdata), .bus_rdata(b_bus_rdata), .read_enable(b_read_enable),
      .write_enable(b_write_enable), .busy(b_busy)
   );

   // LED register plus a switch that returns 16'h3C00 only in the cycle after its strobe.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         a_led       <= '0;
         a_bus_rdata <= '0;
      end else begin
         if (a_write_enable && a_bus_address == LED) a_led <= a_bus_wdata;
         a_bus_rdata <= (a_read_enable && a_bus_address == SW) ? 16'h3C00 : 16'h0000;
      end
   end

   assign b_bus_rdata = {4'hD, cyc[11:0]};

`ifdef BUS_INITIATOR_MIRROR_EN
   logic c_cmd_valid = 0, c_cmd_write = 0, c_cmd_ready, c_rsp_valid;
   logic c_read_enable, c_write_enable, c_busy;
   logic [22:0] c_cmd_addr = '0, c_bus_address;
   logic [15:0] c_cmd_wdata = '0, c_rsp_rdata, c_bus_wdata, c_bus_rdata, c_led;

   bus_initiator #(
      .READ_LATENCY(1), .MIRROR_PERIOD(10)
   ) u_c (
      .clk(clk), .reset(reset), .cmd_valid(c_cmd_valid), .cmd_ready(c_cmd_ready),
      .cmd_write(c_cmd_write), .cmd_addr(c_cmd_addr), .cmd_wdata(c_cmd_wdata),
      .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .bus_address(c_bus_address),
      .bus_wdata(c_bus_wdata), .bus_rdata(c_bus_rdata), .read_enable(c_read_enable),
      .write_enable(c_write_enable), .busy(c_busy)
   );

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         c_led       <= '0;
         c_bus_rdata <= '0;
      end else begin
         if (c_write_enable && c_bus_address == LED) c_led <= c_bus_wdata;
         c_bus_rdata <= (c_read_enable && c_bus_address == SW) ? 16'h00F0 : 16'h0000;
      end
   end
`endif

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({a_cmd_ready, a_busy, a_rsp_valid, a_read_enable, a_write_enable} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctl_a: got %b want 10000",
                  {a_cmd_ready, a_busy, a_rsp_valid, a_read_enable, a_write_enable});
      end
      checks++;
      if ({a_bus_address, a_bus_wdata, a_rsp_rdata} !== 55'd0) begin
         errors++;
         $display("FAIL reset_data_a: got %h want 0", {a_bus_address, a_bus_wdata, a_rsp_rdata});
      end
      checks++;
      if ({b_cmd_ready, b_busy, b_rsp_valid, b_read_enable, b_write_enable} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctl_b: got %b want 10000",
                  {b_cmd_ready, b_busy, b_rsp_valid, b_read_enable, b_write_enable});
      end
      reset = 1'b0;
   endtask

   task automatic test_read();
      logic [3:0] exp, got;
      a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = SW; a_cmd_wdata = 16'hFFFF;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) a_cmd_valid = 1'b0;
         exp = {i == 1, 1'b0, i == 3, i == 4};
         got = {a_read_enable, a_write_enable, a_rsp_valid, a_cmd_ready};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL read_ctl[%0d] re/we/rsp/rdy: got %b want %b", i, got, exp);
         end
         if (i == 1) begin
            checks++;
            if (a_bus_address !== SW) begin
               errors++;
               $display("FAIL read_addr: got %h want %h", a_bus_address, SW);
            end
         end
         if (i == 3) begin
            checks++;
            if (a_rsp_rdata !== 16'h3C00) begin
               errors++;
               $display("FAIL read_data: got %h want 3c00", a_rsp_rdata);
            end
         end
      end
   endtask

   task automatic test_write();
      logic [3:0] exp, got;
      a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = LED; a_cmd_wdata = 16'hA5A5;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         if (i == 1) a_cmd_valid = 1'b0;
         exp = {1'b0, i == 1, i == 2, i == 3};
         got = {a_read_enable, a_write_enable, a_rsp_valid, a_cmd_ready};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL write_ctl[%0d] re/we/rsp/rdy: got %b want %b", i, got, exp);
         end
         if (i == 1) begin
            checks++;
            if ({a_bus_address, a_bus_wdata} !== {LED, 16'hA5A5}) begin
               errors++;
               $display("FAIL write_bus: got %h/%h want %h/a5a5", a_bus_address, a_bus_wdata, LED);
            end
         end
         if (i == 2) begin
            checks++;
            if (a_rsp_rdata !== 16'h0000) begin
               errors++;
               $display("FAIL write_rdata: got %h want 0000", a_rsp_rdata);
            end
         end
      end
      checks++;
      if (a_led !== 16'hA5A5) begin
         errors++;
         $display("FAIL write_led: got %h want a5a5", a_led);
      end
   endtask

   task automatic test_hold_valid();
      int n_we = 0, n_rsp = 0;
      a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = LED; a_cmd_wdata = 16'h1234;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 3) a_cmd_valid = 1'b0;
         if (a_write_enable) n_we++;
         if (a_rsp_valid) n_rsp++;
      end
      checks++;
      if (n_we != 1 || n_rsp != 1) begin
         errors++;
         $display("FAIL hold_once: got we=%0d rsp=%0d want 1/1", n_we, n_rsp);
      end
      checks++;
      if (a_led !== 16'h1234) begin
         errors++;
         $display("FAIL hold_led: got %h want 1234", a_led);
      end
   endtask

   task automatic test_back_to_back();
      int acc[3];
      int n_acc = 0, n_rsp = 0, run = 0;
      b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = SW;
      for (int i = 0; i < 30; i++) begin
         if (b_rsp_valid && n_rsp < 3) begin
            checks++;
            if (n_rsp >= n_acc || int'(cyc) != acc[n_rsp] + 6) begin
               errors++;
               $display("FAIL b2b_rsp_time[%0d]: got cycle %0d", n_rsp, cyc);
            end else begin
               checks++;
               if (b_rsp_rdata !== {4'hD, 12'(acc[n_rsp] + 5)}) begin
                  errors++;
                  $display("FAIL b2b_rsp_data[%0d]: got %h want %h", n_rsp, b_rsp_rdata,
                           {4'hD, 12'(acc[n_rsp] + 5)});
               end
            end
            n_rsp++;
         end
         if (!b_cmd_ready) run++;
         else if (run != 0) begin
            checks++;
            if (run != 6) begin
               errors++;
               $display("FAIL b2b_ready_low: got %0d want 6", run);
            end
            run = 0;
         end
         if (b_cmd_valid && b_cmd_ready && n_acc < 3) begin
            if (n_acc > 0) begin
               checks++;
               if (int'(cyc) - acc[n_acc-1] != 7) begin
                  errors++;
                  $display("FAIL b2b_spacing: got %0d want 7", int'(cyc) - acc[n_acc-1]);
               end
            end
            acc[n_acc] = int'(cyc);
            n_acc++;
         end
         @(negedge clk);
         if (n_acc == 3) b_cmd_valid = 1'b0;
      end
      checks++;
      if (n_acc != 3 || n_rsp != 3) begin
         errors++;
         $display("FAIL b2b_counts: got acc=%0d rsp=%0d want 3/3", n_acc, n_rsp);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp, got;
      int n = 0;
      b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = SW;
      @(negedge clk) b_cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (b_busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_busy_before: got %b want 1", b_busy);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({b_read_enable, b_rsp_valid, b_cmd_ready, b_busy} !== 4'b0010) begin
         errors++;
         $display("FAIL midrst_async re/rsp/rdy/busy: got %b want 0010",
                  {b_read_enable, b_rsp_valid, b_cmd_ready, b_busy});
      end
      @(negedge clk) reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (b_rsp_valid) n++;
      end
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL midrst_no_rsp: got %0d want 0", n);
      end
      b_cmd_valid = 1'b1; b_cmd_write = 1'b1; b_cmd_addr = 23'h000100; b_cmd_wdata = 16'hBEEF;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         if (i == 1) b_cmd_valid = 1'b0;
         exp = {1'b0, i == 1, i == 2, i == 3};
         got = {b_read_enable, b_write_enable, b_rsp_valid, b_cmd_ready};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL midrst_write[%0d] re/we/rsp/rdy: got %b want %b", i, got, exp);
         end
         if (i == 1) begin
            checks++;
            if ({b_bus_address, b_bus_wdata} !== {23'h000100, 16'hBEEF}) begin
               errors++;
               $display("FAIL midrst_write_bus: got %h/%h want 000100/beef",
                        b_bus_address, b_bus_wdata);
            end
         end
      end
   endtask

`ifdef BUS_INITIATOR_MIRROR_EN
   task automatic test_mirror();
      int hit = -1, n_rsp = 0, n_re = 0;
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      for (int n = 1; n <= 29; n++) begin
         @(negedge clk);
         if (n <= 14 && hit < 0 && c_led === 16'h00F0) hit = n;
         if (n <= 18 && c_rsp_valid) n_rsp++;
         if (n >= 20 && c_read_enable) n_re++;
         if (n == 12) begin
            checks++;
            if ({c_cmd_ready, c_busy, c_rsp_valid} !== 3'b010) begin
               errors++;
               $display("FAIL mirror_hold rdy/busy/rsp: got %b want 010",
                        {c_cmd_ready, c_busy, c_rsp_valid});
            end
         end
         if (n == 19) begin
            c_cmd_valid = 1'b1; c_cmd_write = 1'b1;
            c_cmd_addr = 23'h000042; c_cmd_wdata = 16'h5555;
         end
         if (n == 20) begin
            c_cmd_valid = 1'b0;
            checks++;
            if ({c_write_enable, c_bus_address, c_bus_wdata} !== {1'b1, 23'h000042, 16'h5555})
            begin
               errors++;
               $display("FAIL mirror_cmd_wins: got we=%b %h/%h want 1 000042/5555",
                        c_write_enable, c_bus_address, c_bus_wdata);
            end
         end
         if (n == 21) begin
            checks++;
            if ({c_rsp_valid, c_rsp_rdata} !== {1'b1, 16'h0000}) begin
               errors++;
               $display("FAIL mirror_cmd_rsp: got %b/%h want 1/0000", c_rsp_valid, c_rsp_rdata);
            end
         end
      end
      checks++;
      if (hit < 0) begin
         errors++;
         $display("FAIL mirror_led: got %h want 00f0 within 14 cycles", c_led);
      end
      checks++;
      if (n_rsp != 0) begin
         errors++;
         $display("FAIL mirror_no_rsp: got %0d want 0", n_rsp);
      end
      checks++;
      if (n_re != 0 || c_led !== 16'h00F0) begin
         errors++;
         $display("FAIL mirror_skipped: got re=%0d led=%h want 0/00f0", n_re, c_led);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_read();
      test_write();
      test_hold_valid();
      test_back_to_back();
      test_reset_mid();
`ifdef BUS_INITIATOR_MIRROR_EN
      test_mirror();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
